// File: rtl/dmem_arbiter_if.sv
// Data-memory port bundle between the arbiter (master) and the data memory (slave).
interface dmem_arbiter_if #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
);
    logic            req;
    logic            we;
    logic [ALEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic [2:0]      funct3;
    logic            ready;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be, funct3,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be, funct3,
        output ready, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the CPU MEM stage and a DMA/debug port.
// Optional BUSY watchdog enabled by defining DMEM_ARB_TIMEOUT_EN (adds parameter TIMEOUT_CYCLES).
module dmem_arbiter #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
`ifdef DMEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [ALEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    input  logic [3:0]      cpu_be,
    input  logic [2:0]      cpu_funct3,
    output logic            cpu_stall,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            cpu_rvalid,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [ALEN-1:0] dma_addr,
    input  logic [XLEN-1:0] dma_wdata,
    input  logic [3:0]      dma_be,
    output logic [XLEN-1:0] dma_rdata,
    output logic            dma_done,
    dmem_arbiter_if.master  mem,
    output logic            arb_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            last_grant_r;
    logic            owner_r;
    logic            mem_req_r;
    logic            mem_we_r;
    logic [ALEN-1:0] mem_addr_r;
    logic [XLEN-1:0] mem_wdata_r;
    logic [3:0]      mem_be_r;
    logic [2:0]      mem_funct3_r;
    logic [XLEN-1:0] cpu_rdata_r;
    logic            cpu_rvalid_r;
    logic [XLEN-1:0] dma_rdata_r;
    logic            dma_done_r;
    logic            arb_err_r;

    logic            cpu_elig_s;
    logic            dma_elig_s;
    logic            grant_dma_s;
    logic            launch_s;
    logic            complete_s;
    logic            timeout_s;

    // A requester whose completion pulse is high this cycle is being retired and must not re-launch.
    assign cpu_elig_s = cpu_req & ~cpu_rvalid_r;
    assign dma_elig_s = dma_req & ~dma_done_r;

    // Round-robin pick: on a tie the requester that did not win last time goes first.
    always_comb begin
        grant_dma_s = 1'b0;
        if (cpu_elig_s && dma_elig_s) begin
            grant_dma_s = ~last_grant_r;
        end else begin
            grant_dma_s = dma_elig_s;
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] busy_cnt_r;

    // Counts BUSY cycles without mem.ready; cleared on every launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_r <= {CNT_W{1'b0}};
        end else if (launch_s) begin
            busy_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_BUSY) && !mem.ready) begin
            busy_cnt_r <= busy_cnt_r + CNT_W'(1);
        end else begin
            busy_cnt_r <= busy_cnt_r;
        end
    end

    assign timeout_s = (state_r == ST_BUSY) && !mem.ready &&
                       (busy_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_elig_s || dma_elig_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem.ready || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: launch and retire strobes for the datapath.
    always_comb begin
        launch_s   = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            ST_IDLE: launch_s   = cpu_elig_s | dma_elig_s;
            ST_BUSY: complete_s = mem.ready;
            default: begin
                launch_s   = 1'b0;
                complete_s = 1'b0;
            end
        endcase
    end

    // Datapath: latch the winner's access, hold it while BUSY, capture the result for its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= OWN_DMA;
            owner_r      <= OWN_CPU;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ALEN{1'b0}};
            mem_wdata_r  <= {XLEN{1'b0}};
            mem_be_r     <= 4'b0000;
            mem_funct3_r <= 3'b000;
            cpu_rdata_r  <= {XLEN{1'b0}};
            cpu_rvalid_r <= 1'b0;
            dma_rdata_r  <= {XLEN{1'b0}};
            dma_done_r   <= 1'b0;
            arb_err_r    <= 1'b0;
        end else begin
            cpu_rvalid_r <= 1'b0;
            dma_done_r   <= 1'b0;
            arb_err_r    <= 1'b0;
            if (launch_s) begin
                mem_req_r    <= 1'b1;
                owner_r      <= grant_dma_s;
                last_grant_r <= grant_dma_s;
                mem_we_r     <= grant_dma_s ? dma_we    : cpu_we;
                mem_addr_r   <= grant_dma_s ? dma_addr  : cpu_addr;
                mem_wdata_r  <= grant_dma_s ? dma_wdata : cpu_wdata;
                mem_be_r     <= grant_dma_s ? dma_be    : cpu_be;
                // The DMA port has no access type of its own; it always moves whole words.
                mem_funct3_r <= grant_dma_s ? 3'b010    : cpu_funct3;
            end else if (complete_s || timeout_s) begin
                mem_req_r <= 1'b0;
                arb_err_r <= timeout_s;
                if (owner_r == OWN_DMA) begin
                    dma_done_r  <= 1'b1;
                    dma_rdata_r <= complete_s ? mem.rdata : {XLEN{1'b0}};
                end else begin
                    cpu_rvalid_r <= 1'b1;
                    cpu_rdata_r  <= complete_s ? mem.rdata : {XLEN{1'b0}};
                end
            end else begin
                mem_req_r <= mem_req_r;
            end
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_rvalid_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign cpu_rvalid = cpu_rvalid_r;
    assign dma_rdata  = dma_rdata_r;
    assign dma_done   = dma_done_r;
    assign arb_err    = arb_err_r;
    assign mem.req    = mem_req_r;
    assign mem.we     = mem_we_r;
    assign mem.addr   = mem_addr_r;
    assign mem.wdata  = mem_wdata_r;
    assign mem.be     = mem_be_r;
    assign mem.funct3 = mem_funct3_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; the timeout scenario runs when DMEM_ARB_TIMEOUT_EN is defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic [2:0]  cpu_funct3;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic [3:0]  dma_be;
    logic [31:0] dma_rdata;
    logic        dma_done;
    logic        arb_err;
    logic        auto_ready, man_ready;
    logic [31:0] man_rdata;

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if mem_bus ();

    // Memory model: zero-wait when auto_ready, else the bench drives ready by hand.
    assign mem_bus.ready = auto_ready ? mem_bus.req : man_ready;
    assign mem_bus.rdata = man_rdata;

    dmem_arbiter #(
        .XLEN(32),
        .ALEN(32)
`ifdef DMEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_funct3(cpu_funct3), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_be(dma_be), .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem(mem_bus), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        cpu_be = 4'h0; cpu_funct3 = 3'b000;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0; dma_be = 4'h0;
        auto_ready = 1'b0; man_ready = 1'b0; man_rdata = 32'h0;
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_mem_req", mem_bus.req, 1'b0);
        check_eq("rst_mem_addr", mem_bus.addr, 32'h0);
        check_eq("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check_eq("rst_dma_done", dma_done, 1'b0);
        check_eq("rst_arb_err", arb_err, 1'b0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
        check_eq("rst_stall", cpu_stall, 1'b0);
        next_cycle();
        rst = 1'b0;

        // T1: lone CPU load, zero wait states
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_be = 4'hF; cpu_funct3 = 3'b010;
        @(negedge clk);
        check_eq("t1_c0_stall", cpu_stall, 1'b1);
        check_eq("t1_c0_mem_req", mem_bus.req, 1'b0);
        next_cycle();
        man_ready = 1'b1; man_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("t1_c1_mem_req", mem_bus.req, 1'b1);
        check_eq("t1_c1_mem_addr", mem_bus.addr, 32'h100);
        check_eq("t1_c1_stall", cpu_stall, 1'b1);
        next_cycle();
        man_ready = 1'b0;
        @(negedge clk);
        check_eq("t1_c2_rvalid", cpu_rvalid, 1'b1);
        check_eq("t1_c2_rdata", cpu_rdata, 32'hDEADBEEF);
        check_eq("t1_c2_stall", cpu_stall, 1'b0);
        check_eq("t1_c2_mem_req", mem_bus.req, 1'b0);
        // T4: cpu_req was still high in the rvalid cycle; no re-launch may follow
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("t4_c3_rvalid", cpu_rvalid, 1'b0);
        check_eq("t4_c3_mem_req", mem_bus.req, 1'b0);
        next_cycle();
        @(negedge clk);
        check_eq("t4_c4_mem_req", mem_bus.req, 1'b0);
        check_eq("t4_rdata_hold", cpu_rdata, 32'hDEADBEEF);

        // T2: simultaneous CPU/DMA after reset, zero-wait memory, twice
        reset_dut();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_be = 4'hF; cpu_funct3 = 3'b100;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h12345678; dma_be = 4'hF;
        auto_ready = 1'b1; man_rdata = 32'hCAFE0001;
        @(negedge clk);
        check_eq("t2_c0_mem_req", mem_bus.req, 1'b0);
        next_cycle();
        @(negedge clk);
        check_eq("t2_c1_mem_req", mem_bus.req, 1'b1);
        check_eq("t2_c1_addr_cpu", mem_bus.addr, 32'h10);
        check_eq("t2_c1_we", mem_bus.we, 1'b0);
        check_eq("t2_c1_funct3", mem_bus.funct3, 3'b100);
        next_cycle();
        @(negedge clk);
        check_eq("t2_c2_rvalid", cpu_rvalid, 1'b1);
        check_eq("t2_c2_rdata", cpu_rdata, 32'hCAFE0001);
        check_eq("t2_c2_mem_req", mem_bus.req, 1'b0);
        check_eq("t2_c2_dma_done", dma_done, 1'b0);
        next_cycle();
        cpu_req = 1'b0; man_rdata = 32'hCAFE0002;
        @(negedge clk);
        check_eq("t2_c3_mem_req", mem_bus.req, 1'b1);
        check_eq("t2_c3_addr_dma", mem_bus.addr, 32'h20);
        check_eq("t2_c3_we", mem_bus.we, 1'b1);
        check_eq("t2_c3_wdata", mem_bus.wdata, 32'h12345678);
        check_eq("t2_c3_funct3_word", mem_bus.funct3, 3'b010);
        next_cycle();
        @(negedge clk);
        check_eq("t2_c4_dma_done", dma_done, 1'b1);
        check_eq("t2_c4_dma_rdata", dma_rdata, 32'hCAFE0002);
        check_eq("t2_c4_mem_req", mem_bus.req, 1'b0);
        next_cycle();
        cpu_req = 1'b1;
        @(negedge clk);
        check_eq("t2_c5_mem_req", mem_bus.req, 1'b0);
        next_cycle();
        @(negedge clk);
        check_eq("t2_c6_addr_cpu", mem_bus.addr, 32'h10);
        check_eq("t2_c6_mem_req", mem_bus.req, 1'b1);
        next_cycle();
        @(negedge clk);
        check_eq("t2_c7_rvalid", cpu_rvalid, 1'b1);
        check_eq("t2_c7_mem_req", mem_bus.req, 1'b0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("t2_c8_addr_dma", mem_bus.addr, 32'h20);
        check_eq("t2_c8_mem_req", mem_bus.req, 1'b1);
        next_cycle();
        @(negedge clk);
        check_eq("t2_c9_dma_done", dma_done, 1'b1);
        next_cycle();
        dma_req = 1'b0; auto_ready = 1'b0;

        // T3: CPU sb with four wait states; latched fields must hold even if inputs move
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h203; cpu_wdata = 32'hAB;
        cpu_be = 4'b1000; cpu_funct3 = 3'b000; man_rdata = 32'h0;
        @(negedge clk);
        check_eq("t3_c0_mem_req", mem_bus.req, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            if (i == 2) begin
                cpu_addr = 32'h999; cpu_wdata = 32'hFF;
            end
            @(negedge clk);
            check_eq("t3_wait_mem_req", mem_bus.req, 1'b1);
            check_eq("t3_wait_addr", mem_bus.addr, 32'h203);
            check_eq("t3_wait_wdata", mem_bus.wdata, 32'hAB);
            check_eq("t3_wait_be", mem_bus.be, 4'b1000);
            check_eq("t3_wait_rvalid", cpu_rvalid, 1'b0);
        end
        next_cycle();
        man_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_c5_mem_req", mem_bus.req, 1'b1);
        check_eq("t3_c5_rvalid", cpu_rvalid, 1'b0);
        next_cycle();
        man_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_c6_rvalid", cpu_rvalid, 1'b1);
        check_eq("t3_c6_mem_req", mem_bus.req, 1'b0);
        check_eq("t3_c6_arb_err", arb_err, 1'b0);
        check_eq("t3_c6_stall", cpu_stall, 1'b0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("t3_c7_rvalid", cpu_rvalid, 1'b0);
        check_eq("t3_c7_mem_req", mem_bus.req, 1'b0);

        // T5: reset in the second BUSY cycle of a CPU access
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        @(negedge clk);
        check_eq("t5_c0_mem_req", mem_bus.req, 1'b0);
        next_cycle();
        @(negedge clk);
        check_eq("t5_c1_mem_req", mem_bus.req, 1'b1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_c2_mem_req", mem_bus.req, 1'b1);
        next_cycle();
        rst = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h400;
        @(negedge clk);
        check_eq("t5_c3_mem_req", mem_bus.req, 1'b0);
        check_eq("t5_c3_rvalid", cpu_rvalid, 1'b0);
        check_eq("t5_c3_dma_done", dma_done, 1'b0);
        next_cycle();
        @(negedge clk);
        check_eq("t5_c4_mem_req", mem_bus.req, 1'b1);
        check_eq("t5_c4_tie_cpu", mem_bus.addr, 32'h300);
        check_eq("t5_c4_we", mem_bus.we, 1'b0);
        next_cycle();
        man_ready = 1'b1; man_rdata = 32'h55;
        @(negedge clk);
        check_eq("t5_c5_mem_req", mem_bus.req, 1'b1);
        next_cycle();
        man_ready = 1'b0;
        @(negedge clk);
        check_eq("t5_c6_rvalid", cpu_rvalid, 1'b1);
        check_eq("t5_c6_rdata", cpu_rdata, 32'h55);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("t5_c7_addr_dma", mem_bus.addr, 32'h400);
        next_cycle();
        man_ready = 1'b1;
        next_cycle();
        man_ready = 1'b0;
        @(negedge clk);
        check_eq("t5_c9_dma_done", dma_done, 1'b1);
        check_eq("t5_c9_arb_err", arb_err, 1'b0);
        next_cycle();
        dma_req = 1'b0;

`ifdef DMEM_ARB_TIMEOUT_EN
        // T6: DMA read completes once, then a second read times out after 8 BUSY cycles
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
        next_cycle();
        man_ready = 1'b1; man_rdata = 32'h77;
        next_cycle();
        man_ready = 1'b0;
        @(negedge clk);
        check_eq("t6_first_done", dma_done, 1'b1);
        check_eq("t6_first_rdata", dma_rdata, 32'h77);
        next_cycle();
        @(negedge clk);
        check_eq("t6_launch_mem_req", mem_bus.req, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            @(negedge clk);
            check_eq("t6_busy_mem_req", mem_bus.req, 1'b1);
            check_eq("t6_busy_done", dma_done, 1'b0);
        end
        next_cycle();
        @(negedge clk);
        check_eq("t6_to_mem_req", mem_bus.req, 1'b0);
        check_eq("t6_to_done", dma_done, 1'b1);
        check_eq("t6_to_arb_err", arb_err, 1'b1);
        check_eq("t6_to_rdata", dma_rdata, 32'h0);
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check_eq("t6_after_arb_err", arb_err, 1'b0);
        check_eq("t6_after_done", dma_done, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
